// File: rtl/satd_diff_streamer.sv
// Difference front-end for the SATD/SAD datapath: takes one row of ORG/CUR pixels per handshake,
// streams ORG-CUR differences OUT_LANES per beat and reports the block sum of |diff|.
module satd_diff_streamer #(
  parameter int PIX_W     = 8,
  parameter int N_PIX     = 8,
  parameter int OUT_LANES = 1,
  parameter int MAX_ROWS  = 16,
  parameter int ABS_MODE  = 0,
  localparam int SUM_W    = PIX_W + $clog2(N_PIX * MAX_ROWS)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [N_PIX*PIX_W-1:0]         ORG,
  input  logic [N_PIX*PIX_W-1:0]         CUR,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [OUT_LANES*(PIX_W+1)-1:0] out_diff,
  output logic                           out_last,
  output logic                           sad_valid,
  output logic [SUM_W-1:0]               sad_out
);

  localparam int BEATS = N_PIX / OUT_LANES;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int DW    = PIX_W + 1;
  localparam int LW    = OUT_LANES * PIX_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  logic [0:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [N_PIX*PIX_W-1:0] org_sr;
  logic [N_PIX*PIX_W-1:0] cur_sr;
  logic                   last_q;
  logic [SUM_W-1:0]       acc;

  logic             final_beat;
  logic             in_fire;
  logic             out_beat;
  logic [DW-1:0]    lane_diff;
  logic [DW-1:0]    lane_mag;
  logic [SUM_W-1:0] beat_sum;
  logic [SUM_W:0]   acc_sum;
  logic [SUM_W-1:0] acc_next;

  assign final_beat = (cnt == CNT_W'(BEATS - 1));
  assign out_valid  = (state == S_EMIT);
  assign out_last   = out_valid && last_q && final_beat;
  assign out_beat   = out_valid && out_ready;

  // A new row may be taken on the same edge the final beat leaves, so the stream has no bubble.
  assign in_ready = !rst && ((state == S_IDLE) || (final_beat && out_ready));
  assign in_fire  = in_valid && in_ready;

  // NOTE: every always_comb output gets a default before any conditional or loop assignment,
  // otherwise a path that skips the assignment infers a latch.
  always_comb begin
    out_diff  = '0;
    beat_sum  = '0;
    lane_diff = '0;
    lane_mag  = '0;
    for (int j = 0; j < OUT_LANES; j++) begin
      lane_diff = {1'b0, org_sr[j*PIX_W +: PIX_W]} - {1'b0, cur_sr[j*PIX_W +: PIX_W]};
      lane_mag  = lane_diff[DW-1] ? -lane_diff : lane_diff;
      out_diff[j*DW +: DW] = (ABS_MODE != 0) ? lane_mag : lane_diff;
      beat_sum  = beat_sum + SUM_W'(lane_mag);
    end
  end

  // Oversized blocks pin the sum at all-ones instead of wrapping.
  assign acc_sum  = {1'b0, acc} + {1'b0, beat_sum};
  assign acc_next = acc_sum[SUM_W] ? '1 : acc_sum[SUM_W-1:0];

  // NOTE: the pixel shift registers are reset too, because out_diff is derived from them and
  // must read zero out of reset; a partially emitted row is dropped along with them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      cnt       <= '0;
      org_sr    <= '0;
      cur_sr    <= '0;
      last_q    <= 1'b0;
      acc       <= '0;
      sad_valid <= 1'b0;
      sad_out   <= '0;
    end else begin
      // NOTE: all state here uses non-blocking assignments so every register samples the
      // pre-edge values regardless of statement order.
      sad_valid <= 1'b0;
      if (out_beat) begin
        if (out_last) begin
          sad_out   <= acc_next;
          sad_valid <= 1'b1;
          acc       <= '0;
        end else begin
          acc <= acc_next;
        end
      end

      if (in_fire) begin
        org_sr <= ORG;
        cur_sr <= CUR;
        last_q <= in_last;
        cnt    <= '0;
        state  <= S_EMIT;
      end else if (out_beat) begin
        org_sr <= org_sr >> LW;
        cur_sr <= cur_sr >> LW;
        if (final_beat) begin
          cnt   <= '0;
          state <= S_IDLE;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_satd_diff_streamer.sv
// Bench for satd_diff_streamer: table-driven rows with a beat/sum scoreboard on the default
// configuration, plus hand sequences for stalls, back-to-back rows, reset, ABS and 4-lane builds.
module tb_satd_diff_streamer;

  localparam int SUM_W = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        in_valid, a_valid, w_valid, in_last, out_ready;
  logic [63:0] org, cur;

  logic             in_ready, out_valid, out_last, sad_valid;
  logic [8:0]       out_diff;
  logic [SUM_W-1:0] sad_out;

  logic             a_in_ready, a_out_valid, a_out_last, a_sad_valid;
  logic [8:0]       a_out_diff;
  logic [SUM_W-1:0] a_sad_out;

  logic             w_in_ready, w_out_valid, w_out_last, w_sad_valid;
  logic [35:0]      w_out_diff;
  logic [SUM_W-1:0] w_sad_out;

  satd_diff_streamer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .ORG(org), .CUR(cur), .out_valid(out_valid), .out_ready(out_ready), .out_diff(out_diff),
    .out_last(out_last), .sad_valid(sad_valid), .sad_out(sad_out)
  );

  satd_diff_streamer #(.ABS_MODE(1)) dut_abs (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_in_ready), .in_last(in_last),
    .ORG(org), .CUR(cur), .out_valid(a_out_valid), .out_ready(out_ready), .out_diff(a_out_diff),
    .out_last(a_out_last), .sad_valid(a_sad_valid), .sad_out(a_sad_out)
  );

  satd_diff_streamer #(.OUT_LANES(4)) dut_w4 (
    .clk(clk), .rst(rst), .in_valid(w_valid), .in_ready(w_in_ready), .in_last(in_last),
    .ORG(org), .CUR(cur), .out_valid(w_out_valid), .out_ready(out_ready), .out_diff(w_out_diff),
    .out_last(w_out_last), .sad_valid(w_sad_valid), .sad_out(w_sad_out)
  );

  typedef struct {
    logic [7:0] org_base, org_step, cur_base, cur_step;
    bit         last;
    int         exp_sad;
  } vec_t;

  typedef struct packed {
    logic [8:0] d;
    logic       last;
  } beat_t;

  beat_t diff_q[$];
  int    sad_q[$];
  int    beats_seen = 0;
  int    last_sad   = 0;
  int    total      = 0;
  int    bad        = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    total++;
    bad++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [63:0] row(input logic [7:0] base, input logic [7:0] step);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[i*8 +: 8] = base + 8'(i) * step;
    return r;
  endfunction

  // Drives one row into the default instance and records what it must produce.
  task automatic send_row(input logic [63:0] o, input logic [63:0] c, input bit last,
                          input int exp_sad);
    int n = 0;
    org = o; cur = c; in_last = last; in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      fail_now("send_timeout");
      in_valid = 1'b0;
      return;
    end
    for (int i = 0; i < 8; i++) begin
      beat_t b;
      b.d    = {1'b0, o[i*8 +: 8]} - {1'b0, c[i*8 +: 8]};
      b.last = last && (i == 7);
      diff_q.push_back(b);
    end
    if (last) sad_q.push_back(exp_sad);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("accept_latency", out_valid, 1);
  endtask

  task automatic drain();
    int n = 0;
    while ((diff_q.size() != 0 || sad_q.size() != 0) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain", diff_q.size() + sad_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_beats(input int target);
    int n = 0;
    while (beats_seen < target && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("beat_wait", beats_seen, target);
  endtask

  // Scoreboard consumer for the default instance.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      beats_seen++;
      if (diff_q.size() == 0) fail_now("unexpected_beat");
      else begin
        beat_t e;
        e = diff_q.pop_front();
        check("out_diff", out_diff, e.d);
        check("out_last", out_last, e.last);
      end
    end
    if (!rst && sad_valid) begin
      if (sad_q.size() == 0) fail_now("unexpected_sad");
      else begin
        int e;
        e = sad_q.pop_front();
        check("sad_out", sad_out, e);
        last_sad = e;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vec_t        vecs[6];
    int          exp_l[8];
    logic [35:0] w_exp[2];
    int          got, n;

    vecs[0] = '{8'd10,  8'd10, 8'd15,  8'd0,  1'b1, 250};
    vecs[1] = '{8'd0,   8'd0,  8'd255, 8'd0,  1'b1, 2040};
    vecs[2] = '{8'd100, 8'd0,  8'd100, 8'd0,  1'b1, 0};
    vecs[3] = '{8'd200, 8'd0,  8'd0,   8'd30, 1'b1, 780};
    vecs[4] = '{8'd255, 8'd0,  8'd0,   8'd0,  1'b0, 0};
    vecs[5] = '{8'd0,   8'd0,  8'd255, 8'd0,  1'b1, 4080};
    exp_l   = '{-5, 5, 15, 25, 35, 45, 55, 65};

    in_valid = 1'b0; a_valid = 1'b0; w_valid = 1'b0; in_last = 1'b0;
    out_ready = 1'b1; org = '0; cur = '0;
    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_diff", out_diff, 0);
    check("rst_out_last", out_last, 0);
    check("rst_sad_valid", sad_valid, 0);
    check("rst_sad_out", sad_out, 0);
    check("rst_in_ready", in_ready, 0);
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    check("idle_in_ready", in_ready, 1);

    for (int i = 0; i < 6; i++)
      send_row(row(vecs[i].org_base, vecs[i].org_step), row(vecs[i].cur_base, vecs[i].cur_step),
               vecs[i].last, vecs[i].exp_sad);
    drain();

    // Stall at beat 4: lane 3 must hold, then lane 4 follows with nothing lost.
    send_row(row(10, 10), row(15, 0), 1'b1, 250);
    wait_beats(beats_seen + 3);
    out_ready = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_hold_diff", out_diff, 9'd25);
      check("bp_in_ready", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    drain();

    // Two rows back to back: 16 contiguous beats, in_ready only on each row's final beat.
    fork
      begin
        send_row(row(255, 0), row(0, 0), 1'b0, 0);
        send_row(row(10, 10), row(15, 0), 1'b1, 2290);
      end
      begin
        int m;
        m = 0;
        @(negedge clk);
        while (!out_valid && m < 20) begin
          @(negedge clk);
          m++;
        end
        for (int k = 0; k < 16; k++) begin
          check("b2b_valid", out_valid, 1);
          check("b2b_in_ready", in_ready, (k == 7 || k == 15));
          check("b2b_last", out_last, (k == 15));
          if (k < 15) @(negedge clk);
        end
      end
    join
    drain();

    // Exactly MAX_ROWS rows of maximum difference fit; one more row saturates.
    for (int r = 0; r < 16; r++) send_row(row(0, 0), row(255, 0), (r == 15), 32640);
    drain();
    for (int r = 0; r < 17; r++) send_row(row(0, 0), row(255, 0), (r == 16), 32767);
    drain();

    // Reset in the middle of beat 3: the aborted block must not leak into the next sum.
    send_row(row(10, 10), row(15, 0), 1'b1, 250);
    wait_beats(beats_seen + 2);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_diff", out_diff, 0);
    check("mid_rst_in_ready", in_ready, 0);
    diff_q.delete();
    sad_q.delete();
    @(negedge clk) rst = 1'b0;
    @(posedge clk);
    #1;
    send_row(row(10, 10), row(15, 0), 1'b1, 250);
    drain();
    repeat (5) @(posedge clk);
    #1;
    check("sad_hold", sad_out, last_sad);

    // ABS_MODE build: magnitude output.
    org = row(0, 0); cur = row(255, 0); in_last = 1'b1; a_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!a_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("abs_accept", a_in_ready, 1);
    @(posedge clk);
    #1;
    a_valid = 1'b0;
    got = 0; n = 0;
    while (got < 8 && n < 40) begin
      @(negedge clk);
      n++;
      if (a_out_valid) begin
        check("abs_diff", a_out_diff, 9'd255);
        check("abs_last", a_out_last, (got == 7));
        got++;
      end
    end
    check("abs_beats", got, 8);
    n = 0;
    while (!a_sad_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("abs_sad_valid", a_sad_valid, 1);
    check("abs_sad", a_sad_out, 2040);

    // Four-lane build: two beats per row, lane 0 in the low slice.
    for (int b = 0; b < 2; b++)
      for (int j = 0; j < 4; j++) w_exp[b][j*9 +: 9] = 9'(exp_l[b*4 + j]);
    org = row(10, 10); cur = row(15, 0); in_last = 1'b1; w_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!w_in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check("w4_accept", w_in_ready, 1);
    @(posedge clk);
    #1;
    w_valid = 1'b0;
    got = 0; n = 0;
    while (got < 2 && n < 20) begin
      @(negedge clk);
      n++;
      if (w_out_valid) begin
        check("w4_beat", w_out_diff, w_exp[got]);
        check("w4_last", w_out_last, (got == 1));
        got++;
      end
    end
    check("w4_beats", got, 2);
    n = 0;
    while (!w_sad_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("w4_sad_valid", w_sad_valid, 1);
    check("w4_sad", w_sad_out, 250);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
